alu_and_add_conff: RTL and testbench
====================================

Name: alu_and_add_conff

Overview:
- Datapath slice combining three functions:
  - bitwise AND of Y and bus operands;
  - WIDTH-bit adder with carry-in and carry-out;
  - CON flip-flop that evaluates the branch condition encoded in IR C2 against the bus value.
- AND and Add feed the Z register path.
- The CON flip-flop output (branch_met) steers PC update in the control unit.

Parameters:
- WIDTH, 32, operand/bus width; must be a multiple of 4.

Ports:
- Clock  input  1  system clock, rising-edge active.
- Clear  input  1  asynchronous, active-low reset.
- y_in  input  WIDTH  operand A (Y register).
- bus_in  input  WIDTH  operand B / value tested by the CON logic (bus).
- cin  input  1  adder carry-in.
- c2  input  4  branch condition field (IR[22:19]).
- con_in  input  1  CON flip-flop load enable.
- and_out  output  WIDTH  y_in AND bus_in.
- sum  output  WIDTH  low WIDTH bits of y_in + bus_in + cin.
- cout  output  1  carry-out of the addition.
- branch_met  output  1  registered branch decision.

Behaviour:
- and_out:
  - purely combinational, bitwise AND;
  - zero latency, independent of Clock/Clear.
- Adder:
  - purely combinational, unsigned modulo 2^WIDTH;
  - {cout, sum} = y_in + bus_in + cin;
  - built from WIDTH/4 4-bit carry-lookahead slices chained ripple-style;
  - no overflow flag; wrap-around is silent, and carry appears only on cout.
- Condition decode (combinational cond), from c2[1:0]:
  - 00 branch-if-zero: cond = (bus_in == 0).
  - 01 branch-if-nonzero: cond = (bus_in != 0).
  - 10 branch-if-positive: cond = (bus_in[WIDTH-1] == 0); zero counts as positive.
  - 11 branch-if-negative: cond = (bus_in[WIDTH-1] == 1).
  - c2[3:2] are don't-care and must not affect cond.
- CON flip-flop:
  - on rising Clock with con_in=1, branch_met <= cond;
  - with con_in=0, branch_met holds its value.
- Reset:
  - Clear=0 forces branch_met=0 immediately, asynchronously, regardless of Clock/con_in;
  - Clear dominates con_in on the same edge;
  - release on Clear rising; first load occurs on the next qualifying Clock edge.
- Reset mid-operation: combinational outputs (and_out, sum, cout) remain valid during reset; only branch_met is cleared.
- No X propagation from c2[3:2]; all outputs are fully defined for any defined input.

Decomposition:
- Shared package holds:
  - condition codes as localparams COND_ZR=2'b00, COND_NZ=2'b01, COND_PL=2'b10, COND_MI=2'b11;
  - default data width constant 32.
- One natural sub-module: cla4_slice. It is a 4-bit carry-lookahead adder with inputs a[3:0], b[3:0], ci and outputs s[3:0], co, using generate/propagate terms.
- Top generates WIDTH/4 instances and chains the carries.
- AND, condition decode and the CON flop live in the top.

Test Plan:
- AND: y_in=0xF0F0_FF00, bus_in=0x0FF0_F0F0 -> and_out=0x00F0_F000, same cycle.
- Add with wrap:
  - y_in=0xFFFF_FFFF, bus_in=0x0000_0001, cin=0 -> sum=0x0000_0000, cout=1;
  - y_in=0x0000_0025, bus_in=0x0000_0017, cin=1 -> sum=0x0000_003D, cout=0.
- Carry chain: y_in=0x7FFF_FFFF, bus_in=0, cin=1 -> sum=0x8000_0000, cout=0; sweep 1000 random operand/cin triples against a reference model.
- CON codes, each loaded with con_in=1 on one edge:
  - c2=0000, bus_in=0 -> branch_met=1; bus_in=5 -> 0.
  - c2=0001, bus_in=5 -> 1.
  - c2=0010, bus_in=0x8000_0000 -> 0; bus_in=0 -> 1.
  - c2=0011, bus_in=0xFFFF_FFFF -> 1.
  - c2=1100 behaves identically to c2=0000.
- Hold: load branch_met=1, then set con_in=0 and change bus_in/c2 for 3 edges -> branch_met stays 1.
- Reset:
  - with branch_met=1, drive Clear=0 between edges -> branch_met=0 before the next edge;
  - hold Clear=0 with con_in=1 and a true cond across an edge -> branch_met stays 0;
  - release Clear -> next qualifying edge loads cond.

Source files
------------

// File: rtl/alu_and_add_conff_pkg.sv
// Shared constants for the AND/Add/CON datapath slice: default bus width and
// the branch condition codes carried in IR C2[1:0].
package alu_and_add_conff_pkg;

   localparam int DATA_WIDTH_DEF = 32;

   localparam logic [1:0] COND_ZR = 2'b00;
   localparam logic [1:0] COND_NZ = 2'b01;
   localparam logic [1:0] COND_PL = 2'b10;
   localparam logic [1:0] COND_MI = 2'b11;

endpackage : alu_and_add_conff_pkg

// File: rtl/alu_and_add_conff_if.sv
// Operand/result bundle between the control/datapath side (master) and the
// AND/Add/CON slice (slave).
interface alu_and_add_conff_if #(
   parameter int WIDTH = 32
) ();

   logic [WIDTH-1:0] y_in;
   logic [WIDTH-1:0] bus_in;
   logic             cin;
   logic [3:0]       c2;
   logic             con_in;
   logic [WIDTH-1:0] and_out;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             branch_met;

   modport master (
      output y_in, bus_in, cin, c2, con_in,
      input  and_out, sum, cout, branch_met
   );

   modport slave (
      input  y_in, bus_in, cin, c2, con_in,
      output and_out, sum, cout, branch_met
   );

endinterface : alu_and_add_conff_if

// File: rtl/alu_and_add_conff_cla4_slice.sv
// 4-bit carry-lookahead adder slice: all internal carries are flattened
// generate/propagate sums of products of the slice inputs and ci.
module cla4_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   assign c[0] = ci;
   assign c[1] = g[0] | (p[0] & ci);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & ci);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & ci);

   assign s  = p ^ c[3:0];
   assign co = c[4];

endmodule : cla4_slice

// File: rtl/alu_and_add_conff.sv
// AND / add / CON flip-flop datapath slice. AND and the adder are purely
// combinational; only the branch decision (CON flop) is registered.
module alu_and_add_conff
   import alu_and_add_conff_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH_DEF
) (
   input  logic               Clock,
   input  logic               Clear,
   alu_and_add_conff_if.slave alu
);

   localparam int N_SLICES = WIDTH / 4;

   logic [WIDTH-1:0]  sum_w;
   logic [N_SLICES:0] carry;
   logic              cond;
   logic              branch_met_q;
   logic              unused_c2_hi;

   function automatic logic eval_cond(input logic [1:0] code,
                                      input logic [WIDTH-1:0] v);
      logic res;
      res = 1'b0;
      case (code)
         COND_ZR: res = (v == '0);
         COND_NZ: res = (v != '0);
         COND_PL: res = ~v[WIDTH-1];
         COND_MI: res = v[WIDTH-1];
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   assign alu.and_out = alu.y_in & alu.bus_in;

   // Lookahead inside each 4-bit slice, ripple between slices.
   assign carry[0] = alu.cin;

   for (genvar i = 0; i < N_SLICES; i++) begin : g_slice
      cla4_slice u_cla (
         .a  (alu.y_in[4*i +: 4]),
         .b  (alu.bus_in[4*i +: 4]),
         .ci (carry[i]),
         .s  (sum_w[4*i +: 4]),
         .co (carry[i+1])
      );
   end

   assign alu.sum  = sum_w;
   assign alu.cout = carry[N_SLICES];

   // Only the low two bits of C2 select the condition.
   assign unused_c2_hi = ^alu.c2[3:2];
   assign cond         = eval_cond(alu.c2[1:0], alu.bus_in);

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         branch_met_q <= 1'b0;
      end else if (alu.con_in) begin
         branch_met_q <= cond;
      end
   end

   assign alu.branch_met = branch_met_q;

endmodule : alu_and_add_conff

// File: tb/tb_alu_and_add_conff.sv
// Randomised and directed bench for alu_and_add_conff against an arithmetic
// reference model of AND, add-with-carry and the CON branch decision.
module tb_alu_and_add_conff;

   localparam int W = 32;

   logic Clock;
   logic Clear;
   int   errors;
   int   checks;
   logic model_bm;

   alu_and_add_conff_if #(.WIDTH(W)) alu ();

   alu_and_add_conff #(.WIDTH(W)) dut (
      .Clock (Clock),
      .Clear (Clear),
      .alu   (alu.slave)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic ref_cond(input logic [3:0] code,
                                     input logic [W-1:0] v);
      case (code[1:0])
         2'd0:    return v == 0;
         2'd1:    return v != 0;
         2'd2:    return $signed(v) >= 0;
         default: return $signed(v) < 0;
      endcase
   endfunction

   task automatic chk_comb(input string tag);
      logic [W:0] full;
      full = {1'b0, alu.y_in} + {1'b0, alu.bus_in} + {{W{1'b0}}, alu.cin};
      chk({tag, "_and"},  {32'd0, alu.and_out}, {32'd0, alu.y_in & alu.bus_in});
      chk({tag, "_sum"},  {32'd0, alu.sum},     {32'd0, full[W-1:0]});
      chk({tag, "_cout"}, {63'd0, alu.cout},    {63'd0, full[W]});
   endtask

   task automatic drive(input logic [W-1:0] y, input logic [W-1:0] b,
                        input logic ci);
      alu.y_in   = y;
      alu.bus_in = b;
      alu.cin    = ci;
      #1;
   endtask

   // Load at one edge with con_in=1 and compare to a constant expectation.
   task automatic load(input string tag, input logic [3:0] code,
                       input logic [W-1:0] b, input logic want);
      @(negedge Clock);
      alu.c2     = code;
      alu.bus_in = b;
      alu.con_in = 1'b1;
      @(posedge Clock);
      #1;
      chk(tag, {63'd0, alu.branch_met}, {63'd0, want});
      alu.con_in = 1'b0;
   endtask

   initial begin
      errors     = 0;
      checks     = 0;
      model_bm   = 1'b0;
      Clear      = 1'b0;
      alu.y_in   = '0;
      alu.bus_in = '0;
      alu.cin    = 1'b0;
      alu.c2     = 4'b0000;
      alu.con_in = 1'b0;

      #12;
      chk("reset_bm", {63'd0, alu.branch_met}, 64'd0);
      @(negedge Clock);
      Clear = 1'b1;

      // Directed combinational vectors with spec-given values.
      drive(32'hF0F0_FF00, 32'h0FF0_F0F0, 1'b0);
      chk("and_vec", {32'd0, alu.and_out}, 64'h0000_0000_00F0_F000);
      drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      chk("wrap_sum",  {32'd0, alu.sum},  64'd0);
      chk("wrap_cout", {63'd0, alu.cout}, 64'd1);
      drive(32'h0000_0025, 32'h0000_0017, 1'b1);
      chk("cin_sum",  {32'd0, alu.sum},  64'h3D);
      chk("cin_cout", {63'd0, alu.cout}, 64'd0);
      drive(32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
      chk("chain_sum",  {32'd0, alu.sum},  64'h8000_0000);
      chk("chain_cout", {63'd0, alu.cout}, 64'd0);
      drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      chk("max_sum",  {32'd0, alu.sum},  64'hFFFF_FFFF);
      chk("max_cout", {63'd0, alu.cout}, 64'd1);

      // CON condition codes.
      load("zr_true",  4'b0000, 32'd0,          1'b1);
      load("zr_false", 4'b0000, 32'd5,          1'b0);
      load("nz_true",  4'b0001, 32'd5,          1'b1);
      load("pl_neg",   4'b0010, 32'h8000_0000,  1'b0);
      load("pl_zero",  4'b0010, 32'd0,          1'b1);
      load("mi_true",  4'b0011, 32'hFFFF_FFFF,  1'b1);
      load("hi_zr_f",  4'b1100, 32'd5,          1'b0);
      load("hi_zr_t",  4'b1100, 32'd0,          1'b1);

      // Hold with con_in low while operands change.
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         alu.con_in = 1'b0;
         alu.c2     = 4'(i + 1);
         alu.bus_in = 32'h8000_0000 >> i;
         @(posedge Clock);
         #1;
         chk("hold", {63'd0, alu.branch_met}, 64'd1);
      end

      // Asynchronous clear between edges, then clear dominating a load.
      @(negedge Clock);
      #2;
      alu.y_in   = 32'h0000_0010;
      alu.bus_in = 32'd0;
      alu.cin    = 1'b1;
      alu.c2     = 4'b0000;
      Clear      = 1'b0;
      #1;
      chk("async_clr", {63'd0, alu.branch_met}, 64'd0);
      chk("clr_sum", {32'd0, alu.sum}, 64'h11);
      alu.con_in = 1'b1;
      @(posedge Clock);
      #1;
      chk("clr_dom", {63'd0, alu.branch_met}, 64'd0);
      @(negedge Clock);
      Clear = 1'b1;
      @(posedge Clock);
      #1;
      chk("post_clr", {63'd0, alu.branch_met}, 64'd1);
      model_bm = 1'b1;

      // Random sweep: combinational results each cycle, CON flop vs model.
      for (int i = 0; i < 1000; i++) begin
         @(negedge Clock);
         alu.y_in   = $urandom();
         case ($urandom_range(0, 3))
            0:       alu.bus_in = '0;
            1:       alu.bus_in = ~alu.y_in;
            default: alu.bus_in = $urandom();
         endcase
         alu.cin    = 1'($urandom_range(0, 1));
         alu.c2     = 4'($urandom_range(0, 15));
         alu.con_in = 1'($urandom_range(0, 1));
         #1;
         chk_comb("rnd");
         if (alu.con_in) model_bm = ref_cond(alu.c2, alu.bus_in);
         @(posedge Clock);
         #1;
         chk("rnd_bm", {63'd0, alu.branch_met}, {63'd0, model_bm});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_alu_and_add_conff
